// File: rtl/pos_keypad_entry_if.sv
// Keypad entry bundle: cursor/select inputs from the UI side and
// entry, commit and running-total results back out.
interface pos_keypad_entry_if #(
    parameter int MAX_DIGITS = 6,
    parameter int BIN_W      = 20,
    parameter int TOTAL_W    = 32
);
    logic                    enable;
    logic                    btn_sel;
    logic [2:0]              cursor_x;
    logic [3:0]              cursor_y;
    logic                    total_clr;
    logic [4*MAX_DIGITS-1:0] entry_bcd;
    logic [3:0]              digit_cnt;
    logic [BIN_W-1:0]        entry_bin;
    logic                    commit_valid;
    logic [BIN_W-1:0]        commit_bin;
    logic [TOTAL_W-1:0]      total;
    logic                    total_sat;
    logic                    key_err;

    modport master (
        output enable, btn_sel, cursor_x, cursor_y, total_clr,
        input  entry_bcd, digit_cnt, entry_bin, commit_valid,
        input  commit_bin, total, total_sat, key_err
    );

    modport slave (
        input  enable, btn_sel, cursor_x, cursor_y, total_clr,
        output entry_bcd, digit_cnt, entry_bin, commit_valid,
        output commit_bin, total, total_sat, key_err
    );
endinterface

// File: rtl/pos_keypad_entry.sv
// POS keypad numeric entry: decodes the highlighted key on select,
// builds a BCD/binary amount and commits it into a saturating total.
module pos_keypad_entry #(
    parameter int MAX_DIGITS = 6,
    parameter int BIN_W      = 20,
    parameter int TOTAL_W    = 32
) (
    input logic                clk,
    input logic                rst_n,
    pos_keypad_entry_if.slave  kp
);
    localparam int BCD_W = 4 * MAX_DIGITS;
    localparam int SUM_W = ((BIN_W > TOTAL_W) ? BIN_W : TOTAL_W) + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_ENTRY, ST_COMMIT} state_t;

    state_t             state, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, app_bcd;
    logic [BIN_W-1:0]   bin_q, bin_d, app_bin;
    logic [3:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]   cbin_q, cbin_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic [SUM_W-1:0]   sum;

    logic       press, cell_ok, is_digit, is_clr, is_ent;
    logic [3:0] dval;

    // Key map: rows 0-2 are 1..9, row 3 is CLR / 0 / ENT.
    always_comb begin
        press    = kp.btn_sel & kp.enable;
        cell_ok  = (kp.cursor_x <= 3'd2) && (kp.cursor_y <= 4'd3);
        is_digit = 1'b0;
        is_clr   = 1'b0;
        is_ent   = 1'b0;
        dval     = 4'd0;
        if (cell_ok) begin
            if (kp.cursor_y < 4'd3) begin
                is_digit = 1'b1;
                dval = 4'(kp.cursor_y * 4'd3) + {1'b0, kp.cursor_x} + 4'd1;
            end else begin
                case (kp.cursor_x)
                    3'd0:    is_clr = 1'b1;
                    3'd1:    is_digit = 1'b1;
                    default: is_ent = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        app_bcd = (bcd_q << 4) | BCD_W'(dval);
        app_bin = (bin_q * BIN_W'(10)) + BIN_W'(dval);
        sum     = SUM_W'(total_q) + SUM_W'(bin_q);
        state_d = state;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        cbin_d  = cbin_q;
        total_d = total_q;
        sat_d   = sat_q;
        err_d   = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (press && !cell_ok) begin
                    err_d = 1'b1;
                end else if (press && is_digit && dval != 4'd0) begin
                    bcd_d   = app_bcd;
                    bin_d   = app_bin;
                    cnt_d   = 4'd1;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (press && !cell_ok) begin
                    err_d = 1'b1;
                end else if (press && is_digit) begin
                    if (cnt_q < 4'(MAX_DIGITS)) begin
                        bcd_d = app_bcd;
                        bin_d = app_bin;
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (press && is_clr) begin
                    bcd_d   = '0;
                    bin_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_EMPTY;
                end else if (press && is_ent) begin
                    // Commit results land together with the commit_valid pulse.
                    cbin_d = bin_q;
                    if (sum > SUM_W'({TOTAL_W{1'b1}})) begin
                        total_d = '1;
                        sat_d   = 1'b1;
                    end else begin
                        total_d = sum[TOTAL_W-1:0];
                    end
                    bcd_d   = '0;
                    bin_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
        if (kp.total_clr) begin
            total_d = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= 4'd0;
            cbin_q  <= '0;
            total_q <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            cbin_q  <= cbin_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign kp.entry_bcd    = bcd_q;
    assign kp.digit_cnt    = cnt_q;
    assign kp.entry_bin    = bin_q;
    assign kp.commit_valid = (state == ST_COMMIT);
    assign kp.commit_bin   = cbin_q;
    assign kp.total        = total_q;
    assign kp.total_sat    = sat_q;
    assign kp.key_err      = err_q;
endmodule
